// File: rtl/pwm_pkg.sv
// Shared types and helpers for the center-aligned multi-channel PWM.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package pwm_pkg;

    // Shadow periods below this are stretched so the triangle never stalls.
    localparam int MIN_PERIOD = 2;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Phase-load clamp: a requested phase never lands above the active peak.
    function automatic logic [31:0] clamp_load(input logic [31:0] load,
                                               input logic [31:0] per_sh);
        return (load > per_sh) ? per_sh : load;
    endfunction

endpackage

// File: rtl/pwm_center_multi_if.sv
// Register-bank / pad-side bundle of the center-aligned PWM.
// Latency: n/a (wires only).
// Backpressure: none; plain levels, no handshakes.
// Ports: Period, Duty (CHANNELS x WIDTH packed), Load, Load_en in;
//        PWM_o, Delayed_o (CHANNELS) and Valley_o out.
interface pwm_center_multi_if #(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 4
);
    logic [WIDTH-1:0]          Period;
    logic [CHANNELS*WIDTH-1:0] Duty;
    logic [WIDTH-1:0]          Load;
    logic                      Load_en;
    logic [CHANNELS-1:0]       PWM_o;
    logic [CHANNELS-1:0]       Delayed_o;
    logic                      Valley_o;

    modport master (
        output Period, Duty, Load, Load_en,
        input  PWM_o, Delayed_o, Valley_o
    );

    modport slave (
        input  Period, Duty, Load, Load_en,
        output PWM_o, Delayed_o, Valley_o
    );
endinterface

// File: rtl/pwm_delay_line.sv
// Fixed delay of a WIDTH-bit vector by DEPTH cycles in a circular buffer.
// Latency: exactly DEPTH cycles; output masked to 0 until DEPTH writes after reset.
// Backpressure: none; one read and one write every cycle.
// Ports: clk_i, rst_n_i (sync, active-low), din_i in; dout_o out.
module pwm_delay_line #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW:0]      fill_q, fill_d;
    logic             filled;

    always_comb begin
        ptr_d  = ptr_q + PW'(1);
        filled = (fill_q == (PW+1)'(DEPTH));
        fill_d = filled ? fill_q : fill_q + (PW+1)'(1);
        // Read happens before this cycle's write lands, so the slot still
        // holds the sample written DEPTH cycles ago.
        dout_o = filled ? mem_q[ptr_q] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ptr_q  <= '0;
            fill_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            fill_q <= fill_d;
        end
    end

    // Storage is deliberately not reset; the fill mask hides stale contents.
    always_ff @(posedge clk_i) begin
        mem_q[ptr_q] <= din_i;
    end
endmodule

// File: rtl/pwm_center_multi.sv
// Multi-channel center-aligned PWM: shared triangle counter, per-channel duty
// compare double-buffered at the valley, synchronised phase load, and an
// optional fixed-delay copy of the outputs (built only with PWM_DELAY_EN).
// Latency: counter to PWM_o 1 cycle; Load_en pad edge to counter 3 edges.
// Backpressure: none; Period/Duty must be stable during the valley cycle.
// Ports: Clock, Reset_n (sync, active-low); bus (slave): Period, Duty, Load,
//        Load_en in; PWM_o, Delayed_o, Valley_o out.
module pwm_center_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH       = 12,
    parameter int CHANNELS    = 4,
    parameter int DELAY_DEPTH = 16
) (
    input  logic              Clock,
    input  logic              Reset_n,
    pwm_center_multi_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] PMIN = WIDTH'(MIN_PERIOD);

    logic [WIDTH-1:0]                cnt_q, cnt_d;
    dir_t                            dir_q, dir_d;
    logic [WIDTH-1:0]                per_sh_q, per_sh_d, per_eff, load_val;
    logic [CHANNELS-1:0][WIDTH-1:0]  duty_sh_q, duty_sh_d;
    logic [CHANNELS-1:0]             pwm_q, pwm_d;
    logic                            valley_q, valley_d;
    logic                            sync1_q, sync2_q, edge_q;
    logic                            load_fire, shadow_ld;

    if (DELAY_DEPTH < 2 || (DELAY_DEPTH & (DELAY_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DELAY_DEPTH must be a power of two and at least 2");
    end

    always_comb begin
        load_fire = sync2_q & ~edge_q;
        load_val  = WIDTH'(clamp_load(32'(bus.Load), 32'(per_sh_q)));
        per_eff   = (per_sh_q < PMIN) ? PMIN : per_sh_q;

        cnt_d = cnt_q;
        dir_d = dir_q;
        if (cnt_q > per_eff) begin
            // Period shrank or a load overshot: walk down until back in range.
            dir_d = DIR_DOWN;
            cnt_d = cnt_q - ONE;
        end else if (dir_q == DIR_UP) begin
            if (cnt_q >= per_eff) begin
                dir_d = DIR_DOWN;
                cnt_d = cnt_q - ONE;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else begin
            if (cnt_q == '0) begin
                dir_d = DIR_UP;
                cnt_d = cnt_q + ONE;
            end else begin
                cnt_d = cnt_q - ONE;
            end
        end
        if (load_fire) begin
            cnt_d = load_val;
            dir_d = dir_q;
        end

        // A load coinciding with the valley overrides it unless it lands on 0.
        shadow_ld = (cnt_q == '0) && (!load_fire || load_val == '0);
        per_sh_d  = shadow_ld ? bus.Period : per_sh_q;
        duty_sh_d = shadow_ld ? bus.Duty   : duty_sh_q;
        valley_d  = shadow_ld;

        // Compare against the next shadow so the valley output cycle already
        // reflects freshly latched duties.
        pwm_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = (cnt_q < duty_sh_d[i]);
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            cnt_q     <= '0;
            dir_q     <= DIR_UP;
            per_sh_q  <= '0;
            duty_sh_q <= '0;
            pwm_q     <= '0;
            valley_q  <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            edge_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            per_sh_q  <= per_sh_d;
            duty_sh_q <= duty_sh_d;
            pwm_q     <= pwm_d;
            valley_q  <= valley_d;
            sync1_q   <= bus.Load_en;
            sync2_q   <= sync1_q;
            edge_q    <= sync2_q;
        end
    end

    assign bus.PWM_o    = pwm_q;
    assign bus.Valley_o = valley_q;

`ifdef PWM_DELAY_EN
    pwm_delay_line #(
        .WIDTH (CHANNELS),
        .DEPTH (DELAY_DEPTH)
    ) u_delay (
        .clk_i   (Clock),
        .rst_n_i (Reset_n),
        .din_i   (pwm_q),
        .dout_o  (bus.Delayed_o)
    );
`else
    assign bus.Delayed_o = '0;
`endif
endmodule

// File: tb/tb_pwm_center_multi.sv
// Directed bench for pwm_center_multi: reset, steady waveforms, valley-buffered
// duty change, phase load and clamp, mid-period reset, and the delay output.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_pwm_center_multi;
    import pwm_pkg::*;

    localparam int W  = 12;
    localparam int CH = 4;
    localparam int DD = 16;

    logic Clock   = 1'b0;
    logic Reset_n = 1'b0;

    pwm_center_multi_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

    pwm_center_multi #(.WIDTH(W), .CHANNELS(CH), .DELAY_DEPTH(DD)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;
    int duty_m [CH];

    task automatic drive_duty(input int ch, input int val);
        duty_m[ch] = val;
        bus.Duty[ch*W +: W] = W'(val);
    endtask

    function automatic int tri_cnt(input int t, input int per);
        int tt;
        tt = t % (2 * per);
        return (tt <= per) ? tt : 2 * per - tt;
    endfunction

    // Expected outputs for counter value c; channel 0 duty given explicitly.
    function automatic logic [CH-1:0] model_pwm(input int c, input int d0);
        logic [CH-1:0] v;
        v = '0;
        for (int i = 0; i < CH; i++) v[i] = (c < ((i == 0) ? d0 : duty_m[i]));
        return v;
    endfunction

    task automatic test_reset;
        bus.Period  = W'(8);
        bus.Load    = '0;
        bus.Load_en = 1'b0;
        drive_duty(0, 3); drive_duty(1, 0); drive_duty(2, 9); drive_duty(3, 8);
        Reset_n = 1'b0;
        repeat (3) @(negedge Clock);
        n_tests++; if (bus.PWM_o !== 4'b0000) begin n_fail++; $display("FAIL reset_pwm: got %b expected 0000", bus.PWM_o); end
        n_tests++; if (bus.Valley_o !== 1'b0) begin n_fail++; $display("FAIL reset_valley: got %b expected 0", bus.Valley_o); end
        n_tests++; if (bus.Delayed_o !== 4'b0000) begin n_fail++; $display("FAIL reset_delayed: got %b expected 0000", bus.Delayed_o); end
        n_tests++; if (dut.cnt_q !== 12'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", dut.cnt_q); end
        n_tests++; if (dut.per_sh_q !== 12'd0) begin n_fail++; $display("FAIL reset_per_sh: got %0d expected 0", dut.per_sh_q); end
    endtask

    // Period 8: ch0 duty 3 (5 high), ch1 0 (low), ch2 9 (high), ch3 8 (15 high).
    task automatic test_basic;
        bit seen;
        Reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin @(negedge Clock); seen = bus.Valley_o; end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL basic_valley_seen: got none expected pulse within 40 cycles"); end
        for (int t = 0; t < 32; t++) begin
            if (t > 0) @(negedge Clock);
            n_tests++;
            if (bus.PWM_o !== model_pwm(tri_cnt(t, 8), 3)) begin
                n_fail++; $display("FAIL basic_pwm t=%0d: got %b expected %b", t, bus.PWM_o, model_pwm(tri_cnt(t, 8), 3));
            end
            n_tests++;
            if (bus.Valley_o !== ((t % 16) == 0)) begin
                n_fail++; $display("FAIL basic_valley t=%0d: got %b expected %b", t, bus.Valley_o, (t % 16) == 0);
            end
`ifndef PWM_DELAY_EN
            n_tests++;
            if (bus.Delayed_o !== 4'b0000) begin
                n_fail++; $display("FAIL basic_delayed_tied t=%0d: got %b expected 0000", t, bus.Delayed_o);
            end
`endif
        end
    endtask

    // Duty ch0 3 -> 6 on the down-slope: old shape until the valley, then 11 high.
    task automatic test_duty_change;
        bit seen;
        int highs;
        seen = 1'b0;
        highs = 0;
        for (int i = 0; i < 40 && !seen; i++) begin @(negedge Clock); seen = bus.Valley_o; end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL duty_valley_seen: got none expected pulse within 40 cycles"); end
        for (int t = 0; t < 48; t++) begin
            int d0;
            if (t > 0) @(negedge Clock);
            d0 = (t < 16) ? 3 : 6;
            n_tests++;
            if (bus.PWM_o !== model_pwm(tri_cnt(t, 8), d0)) begin
                n_fail++; $display("FAIL duty_change_pwm t=%0d: got %b expected %b", t, bus.PWM_o, model_pwm(tri_cnt(t, 8), d0));
            end
            if (t >= 16 && t < 32 && bus.PWM_o[0] === 1'b1) highs++;
            if (t == 10) drive_duty(0, 6);
        end
        n_tests++; if (highs != 11) begin n_fail++; $display("FAIL duty_change_high_count: got %0d expected 11", highs); end
    endtask

    // Period 1000: 3-cycle Load_en pulse gives one load of 500; 1200 clamps to 1000.
    task automatic test_load;
        bit seen;
        bus.Period = W'(1000);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin @(negedge Clock); seen = bus.Valley_o; end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL load_valley_seen: got none expected pulse within 40 cycles"); end
        for (int t = 1; t <= 34; t++) begin
            @(negedge Clock);
            case (t)
                5: begin n_tests++; if (dut.cnt_q !== 12'd6) begin n_fail++; $display("FAIL load_pre_count: got %0d expected 6", dut.cnt_q); end end
                20: begin bus.Load = W'(500); bus.Load_en = 1'b1; end
                21: begin n_tests++; if (dut.cnt_q !== 12'd22) begin n_fail++; $display("FAIL load_sync_1: got %0d expected 22", dut.cnt_q); end end
                22: begin n_tests++; if (dut.cnt_q !== 12'd23) begin n_fail++; $display("FAIL load_sync_2: got %0d expected 23", dut.cnt_q); end end
                23: begin
                    n_tests++; if (dut.cnt_q !== 12'd500) begin n_fail++; $display("FAIL load_value: got %0d expected 500", dut.cnt_q); end
                    bus.Load_en = 1'b0;
                end
                26: begin n_tests++; if (dut.cnt_q !== 12'd503) begin n_fail++; $display("FAIL load_single_shot: got %0d expected 503", dut.cnt_q); end end
                30: begin bus.Load = W'(1200); bus.Load_en = 1'b1; end
                31: bus.Load_en = 1'b0;
                33: begin n_tests++; if (dut.cnt_q !== 12'd1000) begin n_fail++; $display("FAIL load_clamp: got %0d expected 1000", dut.cnt_q); end end
                34: begin n_tests++; if (dut.cnt_q !== 12'd999) begin n_fail++; $display("FAIL load_peak_turn: got %0d expected 999", dut.cnt_q); end end
                default: ;
            endcase
        end
        drive_duty(2, 4095);
    endtask

    // Reset while counting up through 700: everything clears next cycle.
    task automatic test_reset_mid;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2500 && !seen; i++) begin
            @(negedge Clock);
            seen = (dut.cnt_q == 12'd700) && (dut.dir_q == DIR_UP);
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL mid_reach_700: got none expected up-slope 700 within 2500 cycles"); end
        n_tests++; if (bus.PWM_o !== 4'b0100) begin n_fail++; $display("FAIL mid_pre_pwm: got %b expected 0100", bus.PWM_o); end
        Reset_n = 1'b0;
        @(negedge Clock);
        n_tests++; if (bus.PWM_o !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_pwm: got %b expected 0000", bus.PWM_o); end
        n_tests++; if (bus.Valley_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valley: got %b expected 0", bus.Valley_o); end
        n_tests++; if (bus.Delayed_o !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_delayed: got %b expected 0000", bus.Delayed_o); end
        n_tests++; if (dut.cnt_q !== 12'd0) begin n_fail++; $display("FAIL mid_reset_cnt: got %0d expected 0", dut.cnt_q); end
        Reset_n = 1'b1;
        @(negedge Clock);
        n_tests++; if (bus.Valley_o !== 1'b1) begin n_fail++; $display("FAIL mid_restart_valley: got %b expected 1", bus.Valley_o); end
        n_tests++; if (dut.cnt_q !== 12'd1) begin n_fail++; $display("FAIL mid_restart_cnt: got %0d expected 1", dut.cnt_q); end
        n_tests++; if (bus.PWM_o !== 4'b1101) begin n_fail++; $display("FAIL mid_restart_pwm: got %b expected 1101", bus.PWM_o); end
    endtask

    // Delayed_o: zero for DD cycles after reset, then PWM_o shifted by DD.
    task automatic test_delay;
        logic [CH-1:0] hist [64];
        logic [CH-1:0] exp_d;
        Reset_n = 1'b0;
        @(negedge Clock);
        hist[0] = bus.PWM_o;
        n_tests++; if (bus.Delayed_o !== 4'b0000) begin n_fail++; $display("FAIL delay_t0: got %b expected 0000", bus.Delayed_o); end
        Reset_n = 1'b1;
        for (int t = 1; t < 48; t++) begin
            @(negedge Clock);
            hist[t] = bus.PWM_o;
`ifdef PWM_DELAY_EN
            exp_d = (t >= DD) ? hist[t-DD] : '0;
`else
            exp_d = '0;
`endif
            n_tests++;
            if (bus.Delayed_o !== exp_d) begin
                n_fail++; $display("FAIL delay_t%0d: got %b expected %b", t, bus.Delayed_o, exp_d);
            end
        end
    endtask

    initial begin
        bus.Duty = '0;
        test_reset;
        test_basic;
        test_duty_change;
        test_load;
        test_reset_mid;
        test_delay;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within 500000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/pwm_center_multi.md
# pwm_center_multi

Multi-channel, center-aligned PWM generator: the parametrised successor of the single-channel 12-bit up/down PWM. It uses one shared triangle counter with a programmable period. Each channel has its own duty compare, double-buffered at the valley. A synchronised phase-load input and an optional per-channel fixed-delay output sit alongside. The block sits between the control register bank and the pad drivers.

## Interface
- WIDTH, 12: counter, period and duty width.
- CHANNELS, 4: number of PWM channels.
- DELAY_DEPTH, 16: delay in cycles of Delayed_o relative to PWM_o. Power of two, ≥2.
- Clock  in  1  sole clock; all logic is on the rising edge.
- Reset_n  in  1  reset, synchronous, active-low.
- Period  in  WIDTH  triangle peak value. Sampled into the shadow register at the valley.
- Duty  in  CHANNELS*WIDTH  per-channel compare; channel i occupies bits [i*WIDTH +: WIDTH]. Sampled into the shadow register at the valley.
- Load  in  WIDTH  phase value forced into the counter on a Load_en rising edge.
- Load_en  in  1  phase-load strobe. Asynchronous to Clock.
- PWM_o  out  CHANNELS  registered PWM outputs.
- Delayed_o  out  CHANNELS  PWM_o delayed by DELAY_DEPTH cycles.
- Valley_o  out  1  one-cycle pulse, registered, asserted when counter == 0.

## Operation
- Counter and direction:
  - up: counter+1. On reaching per_sh, direction flips, so the next value is per_sh-1.
  - down: counter-1. On reaching 0, direction flips to up.
  - Triangle period = 2*per_sh cycles.
  - per_sh < 2 is treated as 2.
  - If the counter is above per_sh (the period shrank, or Load exceeded it), direction is forced down until the counter is ≤ per_sh.
- Shadow update:
  - per_sh and all duty_sh[i] load from Period/Duty in every cycle where counter == 0.
  - Mid-period changes to Period/Duty have no effect until the next valley.
- Compare:
  - PWM_o[i] is registered as (counter < duty_sh[i]).
  - duty_sh = 0 gives constantly low.
  - duty_sh > per_sh gives constantly high.
  - For 1 ≤ D ≤ per_sh, the high time is 2D-1 cycles per period, centred on the valley.
- Phase load:
  - Load_en passes through a 2-flop synchroniser plus an edge register.
  - A rising edge (sync=1, previous=0) loads counter <= min(Load, per_sh). Direction is unchanged.
  - The load has priority over the count step in that cycle.
  - A level held high produces exactly one load.
- Delay line:
  - Circular buffer of DELAY_DEPTH x CHANNELS with a single wrap-around pointer.
  - Each cycle it reads the pointer entry, writes PWM_o to the same entry, and increments the pointer (read-before-write).
  - A fill counter masks Delayed_o to 0 until DELAY_DEPTH writes have occurred after reset. Buffer contents are not reset.
- Reset (Reset_n = 0 at an edge):
  - counter = 0, direction = up, per_sh = 0, duty_sh = 0.
  - PWM_o = 0, Delayed_o = 0, Valley_o = 0.
  - Synchroniser and edge register = 0; pointer and fill counter = 0.
  - Reset mid-period aborts the waveform immediately, with no glitch beyond the one-cycle output register.

## Timing
- Counter to PWM_o: 1 cycle of latency.
- Valley_o aligns with the first PWM_o cycle computed from the new shadows.
- Load_en rising at the pad before edge k: the counter holds Load after edge k+2, provided setup is met.
- Delayed_o(t) = PWM_o(t - DELAY_DEPTH) once the buffer is filled.
- Load and valley in the same cycle: the load wins. Shadows latch only if the loaded value is 0.
- No input handshakes. Period/Duty must be stable for the valley cycle.

## Configuration
- PWM_DELAY_EN:
  - Defined: delay line, pointer and fill counter are built; Delayed_o behaves as specified.
  - Undefined: no storage is instantiated and Delayed_o is tied to 0.

## Structure
- Package pwm_pkg holds:
  - MIN_PERIOD = 2
  - the direction typedef (DIR_UP/DIR_DOWN)
  - the clamp function min(Load, per_sh)
- Sub-module pwm_delay_line(WIDTH=CHANNELS, DEPTH=DELAY_DEPTH) contains the buffer, pointer and fill mask. It is instantiated only under PWM_DELAY_EN.

## Test plan
- Period=8, Duty ch0=3: PWM_o[0] high 5 of every 16 cycles, centred on Valley_o; Valley_o period 16.
- Duty ch1=0, ch2=9 with Period=8: ch1 stays low; ch2 stays high.
- Change Duty ch0 from 3 to 6 mid-down-slope: old waveform until the valley, then 11 high cycles per period.
- Period=1000, Load=500 with a 3-cycle Load_en pulse: exactly one load; counter = 500 three edges after assertion; Load=1200 clamps to 1000.
- Reset_n low during the up-slope at counter=700: every output is 0 the next cycle; counter restarts from 0.
- With PWM_DELAY_EN and DELAY_DEPTH=16: Delayed_o is 0 for the first 16 cycles, then matches PWM_o shifted by exactly 16 cycles. Without the macro, Delayed_o stays 0.
